sample_queue: RTL and testbench

Lossy, always-ready sampler with a DEPTH-entry ring buffer behind a registered output stage. It is the generalised successor of the single-register sampler: the upstream producer is never stalled, and bursts up to DEPTH+1 samples are buffered for a slower consumer. On overflow the oldest buffered sample is dropped and counted. HOLD and LATENCY modes match the single-register sampler, so existing sampling points can be migrated without changing their behaviour.

---
 rtl/sample_queue_if.sv | 12 +
 rtl/sample_queue.sv | 99 +++++++++
 tb/tb_sample_queue.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_queue_if.sv
// Valid/ready sample transport between a producer and a consumer.
// The producer drives data/valid and the consumer drives ready.
interface dti #(
    parameter int W = 8
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport producer (output data, output valid, input ready);
    modport consumer (input data, input valid, output ready);
endinterface

// File: rtl/sample_queue.sv
// Lossy, always-ready sampler: a DEPTH-entry ring buffer behind a registered output stage.
// On overflow the oldest ring entry is overwritten and the drop is counted.
module sample_queue #(
    parameter int          DATA_W     = 8,   // must equal the width of the connected dti
    parameter int          DEPTH      = 4,
    parameter int          HOLD       = 1,
    parameter int          LATENCY    = 0,
    parameter logic [63:0] INIT       = '0,
    parameter bit          INIT_VALID = 1'b0,
    parameter int          CNT_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    dti.consumer                         din,
    dti.producer                         dout,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    output logic [CNT_W-1:0]             drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] ring [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] out_reg;
    logic              out_valid;

    logic bypass, dout_vld, hs, load_en, ring_empty, full;
    logic pop, din_taken, wr_en, drop, load_din;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign din.ready = 1'b1;
    assign level     = count;

    always_comb begin
        ring_empty = (count == '0);
        full       = (count == CW'(DEPTH));
        bypass     = (LATENCY == 0) && !out_valid && ring_empty;
        dout_vld   = bypass ? din.valid : out_valid;
        hs         = dout_vld && dout.ready;
        load_en    = !out_valid || hs;
        pop        = load_en && !ring_empty;
        din_taken  = load_en && ring_empty && din.valid;
        // A bypassed sample taken by the consumer this cycle is gone; otherwise it parks in out_reg.
        load_din   = din_taken && !(bypass && hs);
        wr_en      = din.valid && !din_taken;
        drop       = wr_en && full && !pop;
    end

    assign dout.valid = dout_vld;
    assign dout.data  = bypass ? din.data : out_reg;

    // Control state
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= INIT_VALID;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            overflow <= drop;
            if (drop)
                drop_cnt <= sat_inc(drop_cnt);
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop || drop)
                rd_ptr <= rd_ptr + 1'b1;
            if (!drop)
                count <= count + CW'(wr_en) - CW'(pop);
            if (load_en) begin
                if (pop || load_din)
                    out_valid <= 1'b1;
                else if (!din_taken && HOLD == 0)
                    out_valid <= 1'b0;
            end
        end
    end

    // Data path: ring storage is never reset; out_reg only takes INIT when it is marked valid
    always_ff @(posedge clk) begin
        if (wr_en)
            ring[wr_ptr] <= din.data;
        if (rst) begin
            if (INIT_VALID)
                out_reg <= INIT[DATA_W-1:0];
        end else if (pop) begin
            out_reg <= ring[rd_ptr];
        end else if (load_din) begin
            out_reg <= din.data;
        end
    end
endmodule

// File: tb/tb_sample_queue.sv
// Directed bench for sample_queue: a HOLD=1/LATENCY=0 instance and a HOLD=0/LATENCY=1/INIT_VALID=1 instance.
module tb_sample_queue;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [2:0] a_level, b_level;
    logic       a_ovf, b_ovf;
    logic [7:0] a_drop, b_drop;

    dti #(.W(8)) a_in ();
    dti #(.W(8)) a_out ();
    dti #(.W(8)) b_in ();
    dti #(.W(8)) b_out ();

    sample_queue #(.DATA_W(8), .DEPTH(4), .HOLD(1), .LATENCY(0)) u_a (
        .clk(clk), .rst(rst), .din(a_in), .dout(a_out),
        .level(a_level), .overflow(a_ovf), .drop_cnt(a_drop)
    );

    sample_queue #(.DATA_W(8), .DEPTH(4), .HOLD(0), .LATENCY(1),
                   .INIT(64'h3), .INIT_VALID(1'b1)) u_b (
        .clk(clk), .rst(rst), .din(b_in), .dout(b_out),
        .level(b_level), .overflow(b_ovf), .drop_cnt(b_drop)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        a_in.valid = 1'b0; a_in.data = 8'h00; a_out.ready = 1'b0;
        b_in.valid = 1'b0; b_in.data = 8'h00; b_out.ready = 1'b0;
        do_reset();
        mid();
        checks++; if (a_out.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", a_out.valid); end
        checks++; if (a_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", a_level); end
        checks++; if (a_drop !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", a_drop); end
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0h exp 0", a_ovf); end
        cyc();
    endtask

    task automatic test_passthrough();
        a_out.ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            a_in.valid = 1'b1; a_in.data = 8'(i);
            mid();
            checks++; if (a_out.valid !== 1'b1 || a_out.data !== 8'(i)) begin errors++; $display("FAIL pass_data got %0h/%0h exp 1/%0h", a_out.valid, a_out.data, i); end
            checks++; if (a_level !== 3'd0 || a_ovf !== 1'b0) begin errors++; $display("FAIL pass_level got %0d/%0h exp 0/0", a_level, a_ovf); end
            cyc();
        end
        a_in.valid = 1'b0;
        mid();
        checks++; if (a_out.valid !== 1'b0) begin errors++; $display("FAIL pass_idle got %0h exp 0", a_out.valid); end
        cyc();
    endtask

    task automatic test_hold();
        a_out.ready = 1'b0; a_in.valid = 1'b1; a_in.data = 8'h07;
        mid();
        checks++; if (a_out.valid !== 1'b1 || a_out.data !== 8'h07) begin errors++; $display("FAIL hold_first got %0h/%0h exp 1/07", a_out.valid, a_out.data); end
        cyc();
        a_in.valid = 1'b0; a_out.ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mid();
            checks++; if (a_out.valid !== 1'b1 || a_out.data !== 8'h07) begin errors++; $display("FAIL hold_repeat got %0h/%0h exp 1/07", a_out.valid, a_out.data); end
            cyc();
        end
        a_in.valid = 1'b1; a_in.data = 8'h08;
        mid();
        checks++; if (a_out.data !== 8'h07) begin errors++; $display("FAIL hold_before_new got %0h exp 07", a_out.data); end
        cyc();
        a_in.valid = 1'b0;
        mid();
        checks++; if (a_out.valid !== 1'b1 || a_out.data !== 8'h08) begin errors++; $display("FAIL hold_new got %0h/%0h exp 1/08", a_out.valid, a_out.data); end
        cyc();
    endtask

    task automatic test_stability();
        a_out.ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            a_in.valid = 1'b1; a_in.data = 8'h20 + 8'(k);
            mid();
            checks++; if (a_out.valid !== 1'b1 || a_out.data !== 8'h08) begin errors++; $display("FAIL stable_data got %0h/%0h exp 1/08", a_out.valid, a_out.data); end
            cyc();
        end
        a_in.valid = 1'b0; a_out.ready = 1'b1;
        mid();
        checks++; if (a_drop !== 8'd1 || a_level !== 3'd4) begin errors++; $display("FAIL stable_drop got %0d/%0d exp 1/4", a_drop, a_level); end
        cyc();
        mid();
        checks++; if (a_out.data !== 8'h21) begin errors++; $display("FAIL stable_next got %0h exp 21", a_out.data); end
        a_out.ready = 1'b0;
        do_reset();
    endtask

    task automatic test_overflow();
        logic [7:0] exp_seq [5];
        exp_seq = '{8'd10, 8'd13, 8'd14, 8'd15, 8'd16};
        a_out.ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            a_in.valid = 1'b1; a_in.data = 8'd10 + 8'(i);
            mid();
            checks++; if (a_ovf !== (i == 6)) begin errors++; $display("FAIL ovf_pulse_%0d got %0h exp %0h", i, a_ovf, (i == 6)); end
            cyc();
        end
        a_in.valid = 1'b0;
        mid();
        checks++; if (a_ovf !== 1'b1 || a_drop !== 8'd2) begin errors++; $display("FAIL ovf_count got %0h/%0d exp 1/2", a_ovf, a_drop); end
        checks++; if (a_level !== 3'd4 || a_out.data !== 8'd10) begin errors++; $display("FAIL ovf_state got %0d/%0d exp 4/10", a_level, a_out.data); end
        cyc();
        a_out.ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            mid();
            checks++; if (a_out.valid !== 1'b1 || a_out.data !== exp_seq[j]) begin errors++; $display("FAIL drain_%0d got %0h/%0d exp 1/%0d", j, a_out.valid, a_out.data, exp_seq[j]); end
            checks++; if (a_level !== 3'(4 - j)) begin errors++; $display("FAIL drain_level_%0d got %0d exp %0d", j, a_level, 4 - j); end
            if (j == 0) begin
                checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0h exp 0", a_ovf); end
            end
            cyc();
        end
        mid();
        checks++; if (a_out.valid !== 1'b1 || a_out.data !== 8'd16 || a_level !== 3'd0) begin errors++; $display("FAIL drain_hold got %0h/%0d/%0d exp 1/16/0", a_out.valid, a_out.data, a_level); end
        cyc();
    endtask

    task automatic test_reset_mid();
        a_out.ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            a_in.valid = 1'b1; a_in.data = 8'(i);
            cyc();
        end
        a_in.valid = 1'b0;
        mid();
        checks++; if (a_level !== 3'd3 || a_drop !== 8'd2) begin errors++; $display("FAIL rmid_pre got %0d/%0d exp 3/2", a_level, a_drop); end
        cyc();
        rst = 1'b1; a_in.valid = 1'b1; a_in.data = 8'h09;
        cyc();
        rst = 1'b0; a_in.valid = 1'b0;
        mid();
        checks++; if (a_level !== 3'd0 || a_drop !== 8'd0) begin errors++; $display("FAIL rmid_post got %0d/%0d exp 0/0", a_level, a_drop); end
        checks++; if (a_out.valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %0h exp 0", a_out.valid); end
        cyc();
        mid();
        checks++; if (a_out.valid !== 1'b0) begin errors++; $display("FAIL rmid_discard got %0h exp 0", a_out.valid); end
        cyc();
    endtask

    task automatic test_reset_init();
        b_in.valid = 1'b0; b_out.ready = 1'b0;
        do_reset();
        mid();
        checks++; if (b_out.valid !== 1'b1 || b_out.data !== 8'h03) begin errors++; $display("FAIL init_out got %0h/%0h exp 1/03", b_out.valid, b_out.data); end
        checks++; if (b_level !== 3'd0) begin errors++; $display("FAIL init_level got %0d exp 0", b_level); end
        cyc();
    endtask

    task automatic test_registered();
        b_out.ready = 1'b1; b_in.valid = 1'b0;
        mid();
        checks++; if (b_out.valid !== 1'b1 || b_out.data !== 8'h03) begin errors++; $display("FAIL reg_init got %0h/%0h exp 1/03", b_out.valid, b_out.data); end
        cyc();
        b_in.valid = 1'b1; b_in.data = 8'h5A;
        mid();
        checks++; if (b_out.valid !== 1'b0) begin errors++; $display("FAIL reg_nobypass got %0h exp 0", b_out.valid); end
        cyc();
        b_in.valid = 1'b0;
        mid();
        checks++; if (b_out.valid !== 1'b1 || b_out.data !== 8'h5A) begin errors++; $display("FAIL reg_data got %0h/%0h exp 1/5a", b_out.valid, b_out.data); end
        cyc();
        mid();
        checks++; if (b_out.valid !== 1'b0) begin errors++; $display("FAIL reg_nohold got %0h exp 0", b_out.valid); end
        cyc();
    endtask

    task automatic test_back_to_back();
        b_out.ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            b_in.valid = 1'b1; b_in.data = 8'(i);
            mid();
            if (i > 1) begin
                checks++; if (b_out.valid !== 1'b1 || b_out.data !== 8'(i - 1)) begin errors++; $display("FAIL b2b_%0d got %0h/%0h exp 1/%0h", i, b_out.valid, b_out.data, i - 1); end
            end
            cyc();
        end
        b_in.valid = 1'b0;
        mid();
        checks++; if (b_out.valid !== 1'b1 || b_out.data !== 8'd3) begin errors++; $display("FAIL b2b_last got %0h/%0h exp 1/03", b_out.valid, b_out.data); end
        cyc();
        mid();
        checks++; if (b_out.valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %0h exp 0", b_out.valid); end
        cyc();
    endtask

    task automatic test_reset_mid_init();
        b_out.ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            b_in.valid = 1'b1; b_in.data = 8'(i);
            cyc();
        end
        b_in.valid = 1'b0;
        mid();
        checks++; if (b_level !== 3'd3 || b_out.data !== 8'd1) begin errors++; $display("FAIL brmid_pre got %0d/%0h exp 3/01", b_level, b_out.data); end
        cyc();
        rst = 1'b1; b_in.valid = 1'b1; b_in.data = 8'h09;
        cyc();
        rst = 1'b0; b_in.valid = 1'b0;
        mid();
        checks++; if (b_out.valid !== 1'b1 || b_out.data !== 8'h03) begin errors++; $display("FAIL brmid_out got %0h/%0h exp 1/03", b_out.valid, b_out.data); end
        checks++; if (b_level !== 3'd0 || b_drop !== 8'd0) begin errors++; $display("FAIL brmid_level got %0d/%0d exp 0/0", b_level, b_drop); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_hold();
        test_stability();
        test_overflow();
        test_reset_mid();
        test_reset_init();
        test_registered();
        test_back_to_back();
        test_reset_mid_init();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
